// File: rtl/ped_request_ctrl_pkg.sv
// Shared types for the pedestrian request controller: FSM state encoding,
// the registered output bundle and the helper that maps a state to it.
package ped_request_ctrl_pkg;

  localparam int PED_STATE_W = 2;

  typedef enum logic [PED_STATE_W-1:0] {
    PED_IDLE     = 2'd0,
    PED_PENDING  = 2'd1,
    PED_ISSUE    = 2'd2,
    PED_COOLDOWN = 2'd3
  } ped_state_t;

  // Outputs are registered together so they always change on the same edge
  // as the state they describe.
  typedef struct packed {
    logic pass;
    logic wait_led;
    logic cool_active;
  } ped_out_t;

  // Output values that belong to a given state. Callers pass the state being
  // entered, so the output flops line up with the state flops.
  // wait_led and cool_active are mutually exclusive by construction here.
  function automatic ped_out_t ped_outputs(input ped_state_t s);
    ped_out_t o;
    o = '0;
    case (s)
      PED_PENDING: begin
        o.wait_led = 1'b1;
      end
      PED_ISSUE: begin
        o.pass     = 1'b1;
        o.wait_led = 1'b1;
      end
      PED_COOLDOWN: begin
        o.cool_active = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ped_request_ctrl_btn_debounce.sv
// Button front end: two-flop synchroniser, saturating debounce counter and
// a rise detector that turns a stable press into a single-cycle pulse.
module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             btn_m;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  logic             deb;
  logic             deb_d;

  // Bring the asynchronous button into the clk domain through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // Count consecutive high samples; deb asserts on the edge the count
  // reaches DEB_CYC and drops on the first low sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (!btn_s) begin
      cnt <= '0;
      deb <= 1'b0;
    end else begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
      deb <= (cnt >= (CNT_MAX - CNT_ONE));
    end
  end

  // Delayed copy of deb so only its rising edge produces a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_d <= 1'b0;
    end else begin
      deb_d <= deb;
    end
  end

  assign press = deb & ~deb_d;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: debounced button presses become a single
// pass pulse, issued only while the light is green, followed by a cooldown
// during which at most one further request can be queued.
module ped_request_ctrl
  import ped_request_ctrl_pkg::*;
#(
  parameter int DEB_CYC  = 4,
  parameter int COOL_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic G,
  output logic pass,
  output logic wait_led,
  output logic cool_active
);

  localparam int COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOL_CYC - 1);
  localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);

  logic              press;
  ped_state_t        state;
  logic [COOL_W-1:0] cool_cnt;
  logic              queued;
  ped_out_t          outs;

  btn_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  // Request FSM with cooldown counter and single-entry queue. Outputs are
  // loaded from the state being entered so they are registered with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PED_IDLE;
      cool_cnt <= '0;
      queued   <= 1'b0;
      outs     <= '0;
    end else begin
      case (state)
        PED_IDLE: begin
          if (press) begin
            state <= PED_PENDING;
            outs  <= ped_outputs(PED_PENDING);
          end
        end

        PED_PENDING: begin
          if (G) begin
            state <= PED_ISSUE;
            outs  <= ped_outputs(PED_ISSUE);
          end
        end

        PED_ISSUE: begin
          state    <= PED_COOLDOWN;
          outs     <= ped_outputs(PED_COOLDOWN);
          cool_cnt <= COOL_LOAD;
          queued   <= 1'b0;
        end

        PED_COOLDOWN: begin
          if (cool_cnt == '0) begin
            queued <= 1'b0;
            if (queued || press) begin
              state <= PED_PENDING;
              outs  <= ped_outputs(PED_PENDING);
            end else begin
              state <= PED_IDLE;
              outs  <= ped_outputs(PED_IDLE);
            end
          end else begin
            cool_cnt <= cool_cnt - COOL_ONE;
            if (press) begin
              queued <= 1'b1;
            end
          end
        end

        default: begin
          state <= PED_IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

  assign pass        = outs.pass;
  assign wait_led    = outs.wait_led;
  assign cool_active = outs.cool_active;

endmodule
